shift_frame_sequencer: RTL and testbench

Upstream controller for the universal shift register (mode/si/din interface, so_left/so_right taps). Accepts parallel words over a valid/ready handshake and drives the register's mode, din and si to load each word. It then shifts the word out serially, MSB- or LSB-first, at a programmable bit rate. The block provides a qualified serial output, frame-done signalling and an optional inter-frame gap.

---
 rtl/shift_frame_sequencer.sv | 151 +++++++++++++++
 tb/tb_shift_frame_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_frame_sequencer.sv
// Upstream sequencer for a universal shift register: loads a word, shifts it out serially at cfg_div+1 cycles per bit.
// Optional define SHIFT_FRAME_LOOPBACK_EN feeds the outgoing bit back into sr_si so the register rotates.
module shift_frame_sequencer #(
    parameter int WIDTH      = 8,
    parameter int DIV_W      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             cfg_msb_first,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             abort,
    output logic [1:0]       sr_mode,
    output logic [WIDTH-1:0] sr_din,
    output logic             sr_si,
    input  logic             sr_so_left,
    input  logic             sr_so_right,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             frame_done
);
    localparam int BIT_W = $clog2(WIDTH);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic             msb_q, msb_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             done_q, done_d;
    logic             shift_tick;
    logic             last_shift;
    logic             accept;
    logic             leaving_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            din_q     <= '0;
            msb_q     <= 1'b0;
            div_q     <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            din_q     <= din_d;
            msb_q     <= msb_d;
            div_q     <= div_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            done_q    <= done_d;
        end
    end

    // With no gap configured, in_ready rises on the final shift cycle so the next word's LOAD follows immediately.
    always_comb begin
        state_d    = state_q;
        din_d      = din_q;
        msb_d      = msb_q;
        div_d      = div_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        done_d     = 1'b0;
        sr_mode    = 2'b00;
        in_ready   = 1'b0;
        shift_tick = (state_q == SHIFT) && (div_cnt_q == div_q);
        last_shift = shift_tick && (bit_cnt_q == BIT_LAST);

        case (state_q)
            IDLE: in_ready = 1'b1;
            LOAD: begin
                sr_mode   = 2'b11;
                state_d   = SHIFT;
                bit_cnt_d = '0;
                div_cnt_d = '0;
            end
            SHIFT: begin
                if (shift_tick) begin
                    sr_mode   = msb_q ? 2'b01 : 2'b10;
                    div_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (last_shift) begin
                        done_d    = 1'b1;
                        bit_cnt_d = '0;
                        gap_cnt_d = '0;
                        if (GAP_CYCLES == 0) begin
                            state_d  = IDLE;
                            in_ready = 1'b1;
                        end else begin
                            state_d = GAP;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
        endcase

        accept = in_valid && in_ready && !abort;
        if (accept) begin
            din_d   = in_data;
            msb_d   = cfg_msb_first;
            div_d   = cfg_div;
            state_d = LOAD;
        end

        if (abort) begin
            state_d   = IDLE;
            sr_mode   = 2'b00;
            div_cnt_d = '0;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            done_d    = 1'b0;
        end
    end

    assign leaving_bit = msb_q ? sr_so_left : sr_so_right;
    assign sr_din      = din_q;
    assign busy        = (state_q != IDLE);
    assign frame_done  = done_q;
    assign ser_valid   = (state_q == SHIFT) && (div_cnt_q == '0);
    assign ser_out     = (state_q == SHIFT) && leaving_bit;

`ifdef SHIFT_FRAME_LOOPBACK_EN
    assign sr_si = leaving_bit;
`else
    assign sr_si = 1'b0;
`endif

endmodule

// File: tb/tb_shift_frame_sequencer.sv
// Self-checking bench for shift_frame_sequencer: a table of frames plus abort, reset and back-to-back sequences,
// with a behavioural downstream shift register and a serial-bit scoreboard per instance.
module tb_shift_frame_sequencer;

    typedef struct {
        logic [7:0] data;
        logic       msb;
        logic [7:0] div;
        logic [7:0] expStream;
        logic [7:0] expFinalQ;
    } frameVec_t;

`ifdef SHIFT_FRAME_LOOPBACK_EN
    localparam bit LOOPBACK = 1'b1;
`else
    localparam bit LOOPBACK = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       inValid, inReady, abort;
    logic [7:0] inData;
    logic       cfgMsb;
    logic [7:0] cfgDiv;
    logic [1:0] srMode;
    logic [7:0] srDin;
    logic       srSi, soLeft, soRight;
    logic       serOut, serValid, busy, frameDone;
    logic [7:0] dsQ;

    logic       inValidB, inReadyB;
    logic [7:0] inDataB;
    logic [1:0] srModeB;
    logic [7:0] srDinB;
    logic       srSiB, soLeftB, soRightB;
    logic       serOutB, serValidB, busyB, frameDoneB;
    logic [7:0] dsQB;

    int checks   = 0;
    int failures = 0;
    logic expQ[$];
    logic expQB[$];

    shift_frame_sequencer #(.WIDTH(8), .DIV_W(8), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady), .in_data(inData),
        .cfg_msb_first(cfgMsb), .cfg_div(cfgDiv), .abort(abort), .sr_mode(srMode), .sr_din(srDin),
        .sr_si(srSi), .sr_so_left(soLeft), .sr_so_right(soRight), .ser_out(serOut),
        .ser_valid(serValid), .busy(busy), .frame_done(frameDone)
    );

    shift_frame_sequencer #(.WIDTH(8), .DIV_W(8), .GAP_CYCLES(0)) dutB (
        .clk(clk), .rst_n(rst_n), .in_valid(inValidB), .in_ready(inReadyB), .in_data(inDataB),
        .cfg_msb_first(cfgMsb), .cfg_div(cfgDiv), .abort(1'b0), .sr_mode(srModeB), .sr_din(srDinB),
        .sr_si(srSiB), .sr_so_left(soLeftB), .sr_so_right(soRightB), .ser_out(serOutB),
        .ser_valid(serValidB), .busy(busyB), .frame_done(frameDoneB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream universal shift registers, reset by the same rst_n as the sequencers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsQ  <= 8'h00;
            dsQB <= 8'h00;
        end else begin
            case (srMode)
                2'b01:   dsQ <= {dsQ[6:0], srSi};
                2'b10:   dsQ <= {srSi, dsQ[7:1]};
                2'b11:   dsQ <= srDin;
                default: dsQ <= dsQ;
            endcase
            case (srModeB)
                2'b01:   dsQB <= {dsQB[6:0], srSiB};
                2'b10:   dsQB <= {srSiB, dsQB[7:1]};
                2'b11:   dsQB <= srDinB;
                default: dsQB <= dsQB;
            endcase
        end
    end
    assign soLeft   = dsQ[7];
    assign soRight  = dsQ[0];
    assign soLeftB  = dsQB[7];
    assign soRightB = dsQB[0];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Scoreboards: every qualified serial bit is popped and compared in order
    always @(negedge clk) begin
        if (rst_n && serValid) begin
            if (expQ.size() == 0) checkOutput("ser_unexpected", 32'd1, 32'd0);
            else checkOutput("ser_bit", 32'(serOut), 32'(expQ.pop_front()));
        end
        if (rst_n && !busy) checkOutput("ser_out_idle", 32'(serOut), 32'd0);
        if (rst_n && serValidB) begin
            if (expQB.size() == 0) checkOutput("serB_unexpected", 32'd1, 32'd0);
            else checkOutput("serB_bit", 32'(serOutB), 32'(expQB.pop_front()));
        end
    end

    // Presents a word at a negedge and returns at the negedge of the LOAD cycle
    task automatic applyStimulus(input frameVec_t v);
        int waitCycles = 0;
        inValid = 1'b1;
        inData  = v.data;
        cfgMsb  = v.msb;
        cfgDiv  = v.div;
        while (!inReady && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!inReady) checkOutput("accept_timeout", 32'(inReady), 32'd1);
        for (int i = 7; i >= 0; i--) expQ.push_back(v.expStream[i]);
        @(negedge clk);
        inValid = 1'b0;
        inData  = ~v.data;
        cfgMsb  = ~v.msb;
        cfgDiv  = v.div ^ 8'hFF;
        checkOutput("load_mode", 32'(srMode), 32'd3);
        checkOutput("load_din", 32'(srDin), 32'(v.data));
        checkOutput("load_busy", 32'(busy), 32'd1);
        checkOutput("load_valid", 32'(serValid), 32'd0);
    endtask

    task automatic checkFrame(input frameVec_t v);
        int period = int'(v.div) + 1;
        for (int c = 0; c < 8 * period; c++) begin
            @(negedge clk);
            checkOutput("shift_valid", 32'(serValid), 32'((c % period) == 0));
            checkOutput("shift_mode", 32'(srMode),
                        ((c % period) == period - 1) ? (v.msb ? 32'd1 : 32'd2) : 32'd0);
            checkOutput("shift_done_early", 32'(frameDone), 32'd0);
            checkOutput("shift_ready", 32'(inReady), 32'd0);
        end
        @(negedge clk);
        checkOutput("frame_done", 32'(frameDone), 32'd1);
        checkOutput("gap1_ready", 32'(inReady), 32'd0);
        checkOutput("final_q", 32'(dsQ), 32'(v.expFinalQ));
        @(negedge clk);
        checkOutput("frame_done_pulse", 32'(frameDone), 32'd0);
        checkOutput("gap2_ready", 32'(inReady), 32'd0);
        checkOutput("gap2_busy", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("idle_ready", 32'(inReady), 32'd1);
        checkOutput("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_mode"}, 32'(srMode), 32'd0);
        checkOutput({tag, "_din"}, 32'(srDin), 32'd0);
        checkOutput({tag, "_ready"}, 32'(inReady), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_valid"}, 32'(serValid), 32'd0);
        checkOutput({tag, "_done"}, 32'(frameDone), 32'd0);
        checkOutput({tag, "_serout"}, 32'(serOut), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        frameVec_t vectors[4];
        frameVec_t v;
        vectors[0] = '{8'hA5, 1'b1, 8'd0, 8'hA5, LOOPBACK ? 8'hA5 : 8'h00};
        vectors[1] = '{8'h01, 1'b0, 8'd3, 8'h80, LOOPBACK ? 8'h01 : 8'h00};
        vectors[2] = '{8'hC3, 1'b1, 8'd1, 8'hC3, LOOPBACK ? 8'hC3 : 8'h00};
        vectors[3] = '{8'h6E, 1'b0, 8'd2, 8'h76, LOOPBACK ? 8'h6E : 8'h00};

        rst_n = 1'b0; inValid = 1'b0; inData = 8'h00; cfgMsb = 1'b0; cfgDiv = 8'h00; abort = 1'b0;
        inValidB = 1'b0; inDataB = 8'h00;
        @(negedge clk);
        @(negedge clk);
        checkResetValues("reset");
        checkOutput("resetB_ready", 32'(inReadyB), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vectors[i]);
            checkFrame(vectors[i]);
        end

        // Abort during the third bit of a 0xFF frame, then abort beating a pending accept in IDLE
        v = '{8'hFF, 1'b1, 8'd0, 8'hFF, 8'h00};
        applyStimulus(v);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        #1;
        checkOutput("abort_mode", 32'(srMode), 32'd0);
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_ready", 32'(inReady), 32'd1);
        checkOutput("abort_idle_mode", 32'(srMode), 32'd0);
        checkOutput("abort_no_done", 32'(frameDone), 32'd0);
        inValid = 1'b1;
        inData  = 8'h99;
        @(negedge clk);
        checkOutput("abort_blocks_accept", 32'(busy), 32'd0);
        checkOutput("abort_no_done2", 32'(frameDone), 32'd0);
        expQ.delete();
        abort   = 1'b0;
        inValid = 1'b0;
        v = '{8'h3C, 1'b1, 8'd0, 8'h3C, LOOPBACK ? 8'h3C : 8'h00};
        applyStimulus(v);
        checkFrame(v);

        // Reset asserted mid-SHIFT, then a clean frame
        v = '{8'h5A, 1'b1, 8'd1, 8'h5A, 8'h00};
        applyStimulus(v);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v = '{8'h96, 1'b1, 8'd0, 8'h96, LOOPBACK ? 8'h96 : 8'h00};
        applyStimulus(v);
        checkFrame(v);

        // Back-to-back frames on the zero-gap instance with in_valid held high
        cfgMsb = 1'b1;
        cfgDiv = 8'd0;
        checkOutput("b2b_ready0", 32'(inReadyB), 32'd1);
        inValidB = 1'b1;
        inDataB  = 8'h11;
        for (int i = 7; i >= 0; i--) expQB.push_back(inDataB[i]);
        @(negedge clk);
        checkOutput("b2b_load1", 32'(srModeB), 32'd3);
        inDataB = 8'h22;
        for (int i = 7; i >= 0; i--) expQB.push_back(inDataB[i]);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("b2b_valid1", 32'(serValidB), 32'd1);
            if (i == 7) checkOutput("b2b_ready_last", 32'(inReadyB), 32'd1);
        end
        @(negedge clk);
        inValidB = 1'b0;
        checkOutput("b2b_gap_valid", 32'(serValidB), 32'd0);
        checkOutput("b2b_load2", 32'(srModeB), 32'd3);
        checkOutput("b2b_load2_din", 32'(srDinB), 32'h22);
        checkOutput("b2b_done1", 32'(frameDoneB), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("b2b_valid2", 32'(serValidB), 32'd1);
        end
        @(negedge clk);
        checkOutput("b2b_end_valid", 32'(serValidB), 32'd0);
        checkOutput("b2b_done2", 32'(frameDoneB), 32'd1);
        checkOutput("b2b_end_busy", 32'(busyB), 32'd0);
        checkOutput("b2b_end_ready", 32'(inReadyB), 32'd1);

        @(negedge clk);
        checkOutput("scoreboard_drain", 32'(expQ.size()), 32'd0);
        checkOutput("scoreboardB_drain", 32'(expQB.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
